inicia: RTL and testbench

INICIA -- requirements
Module: inicia

---
 rtl/inicia.sv | 177 +++++++++++++++++
 tb/tb_inicia.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/inicia.sv
// inicia: after reset or a re-initialization request, writes a fixed six-entry
// table to an external RTC over a multiplexed address/data bus. Each entry is
// written in 24 cycles: a 10-cycle address phase, a 10-cycle data phase and a
// 4-cycle recovery. Every output is registered and is computed from the next
// state, so the strobes always line up with the displayed counter values.
module inicia (
    input  logic       clk,
    input  logic       reset,
    input  logic       date,
    input  logic       stime,
    input  logic       timer,
    output logic [7:0] AD,
    output logic [3:0] control,
    output logic [7:0] contador,
    output logic [1:0] cont,
    output logic [5:0] counter
);

    typedef enum logic [1:0] {
        PH_ADDR  = 2'd0,
        PH_DATA  = 2'd1,
        PH_RECOV = 2'd2,
        PH_IDLE  = 2'd3
    } phase_t;

    localparam logic [7:0] LAST_IDX  = 8'd5;
    localparam logic [7:0] IDLE_IDX  = 8'd6;
    localparam logic [5:0] LAST_CNT  = 6'd23;
    localparam logic [3:0] CTL_QUIET = 4'b1110;

    // Register address for each table entry.
    function automatic logic [7:0] tbl_addr(input logic [7:0] idx);
        logic [7:0] a;
        case (idx)
            8'd0:    a = 8'h02;
            8'd1:    a = 8'h02;
            8'd2:    a = 8'h10;
            8'd3:    a = 8'h00;
            8'd4:    a = 8'h01;
            8'd5:    a = 8'hF1;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // Data value for each table entry.
    function automatic logic [7:0] tbl_data(input logic [7:0] idx);
        logic [7:0] d;
        case (idx)
            8'd0:    d = 8'h10;
            8'd1:    d = 8'h00;
            8'd2:    d = 8'hD2;
            8'd3:    d = 8'h00;
            8'd4:    d = 8'h00;
            8'd5:    d = 8'h00;
            default: d = 8'h00;
        endcase
        return d;
    endfunction

    // Phase implied by a cycle count inside one write.
    function automatic phase_t phase_of(input logic [5:0] cnt);
        phase_t p;
        if (cnt < 6'd10) begin
            p = PH_ADDR;
        end else if (cnt < 6'd20) begin
            p = PH_DATA;
        end else begin
            p = PH_RECOV;
        end
        return p;
    endfunction

    phase_t     phase_r;
    logic       start_r;     // set by reset: load idx0 on the first edge after release

    phase_t     nxt_phase_s;
    logic [7:0] nxt_idx_s;
    logic [5:0] nxt_cnt_s;
    logic [5:0] local_k_s;
    logic [7:0] nxt_ad_s;
    logic [3:0] nxt_ctl_s;
    logic       cs_n_s;
    logic       wr_n_s;
    logic       a_d_s;
    logic       req_s;

    assign cont  = phase_r;
    assign req_s = date | stime | timer;

    // Next state of the write sequencer; requests only matter while idle.
    always_comb begin
        nxt_phase_s = phase_r;
        nxt_idx_s   = contador;
        nxt_cnt_s   = counter;
        if (start_r) begin
            nxt_phase_s = PH_ADDR;
            nxt_idx_s   = 8'd0;
            nxt_cnt_s   = 6'd0;
        end else if (phase_r == PH_IDLE) begin
            if (req_s) begin
                nxt_phase_s = PH_ADDR;
                nxt_idx_s   = 8'd0;
                nxt_cnt_s   = 6'd0;
            end else begin
                nxt_phase_s = PH_IDLE;
                nxt_idx_s   = IDLE_IDX;
                nxt_cnt_s   = 6'd0;
            end
        end else if (counter >= LAST_CNT) begin
            nxt_cnt_s = 6'd0;
            if (contador >= LAST_IDX) begin
                nxt_idx_s   = IDLE_IDX;
                nxt_phase_s = PH_IDLE;
            end else begin
                nxt_idx_s   = contador + 8'd1;
                nxt_phase_s = PH_ADDR;
            end
        end else begin
            nxt_cnt_s   = counter + 6'd1;
            nxt_phase_s = phase_of(counter + 6'd1);
        end
    end

    // Bus value and strobes for the next state; bus is constant over a phase.
    always_comb begin
        local_k_s = 6'd0;
        nxt_ad_s  = 8'h00;
        a_d_s     = 1'b0;
        cs_n_s    = 1'b1;
        wr_n_s    = 1'b1;
        case (nxt_phase_s)
            PH_ADDR: begin
                local_k_s = nxt_cnt_s;
                nxt_ad_s  = tbl_addr(nxt_idx_s);
                a_d_s     = 1'b0;
                cs_n_s    = !((local_k_s >= 6'd1) && (local_k_s <= 6'd8));
                wr_n_s    = !((local_k_s >= 6'd2) && (local_k_s <= 6'd7));
            end
            PH_DATA: begin
                local_k_s = nxt_cnt_s - 6'd10;
                nxt_ad_s  = tbl_data(nxt_idx_s);
                a_d_s     = 1'b1;
                cs_n_s    = !((local_k_s >= 6'd1) && (local_k_s <= 6'd8));
                wr_n_s    = !((local_k_s >= 6'd2) && (local_k_s <= 6'd7));
            end
            default: begin
                local_k_s = 6'd0;
                nxt_ad_s  = 8'h00;
                a_d_s     = 1'b0;
                cs_n_s    = 1'b1;
                wr_n_s    = 1'b1;
            end
        endcase
        nxt_ctl_s = {cs_n_s, 1'b1, wr_n_s, a_d_s};
    end

    // State and output registers; reset aborts any write in progress at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_r  <= 1'b1;
            phase_r  <= PH_ADDR;
            contador <= 8'd0;
            counter  <= 6'd0;
            AD       <= 8'h00;
            control  <= CTL_QUIET;
        end else begin
            start_r  <= 1'b0;
            phase_r  <= nxt_phase_s;
            contador <= nxt_idx_s;
            counter  <= nxt_cnt_s;
            AD       <= nxt_ad_s;
            control  <= nxt_ctl_s;
        end
    end

endmodule

// File: tb/tb_inicia.sv
// Directed bench for inicia. A position-based model (cycle number within the
// 144-cycle table write, or reset / idle) predicts every output; a compare
// process checks it each falling edge, and literal checks pin the model.
module tb_inicia;

    logic       clk;
    logic       reset;
    logic       date;
    logic       stime;
    logic       timer;
    logic [7:0] ad;
    logic [3:0] control;
    logic [7:0] contador;
    logic [1:0] cont;
    logic [5:0] counter;

    int vectors     = 0;
    int miscompares = 0;
    int pos         = -1;   // -1 reset, 0..143 sequence position, >=144 idle
    bit run_en      = 1'b0;

    logic [7:0] taddr [6] = '{8'h02, 8'h02, 8'h10, 8'h00, 8'h01, 8'hF1};
    logic [7:0] tdata [6] = '{8'h10, 8'h00, 8'hD2, 8'h00, 8'h00, 8'h00};

    inicia dut (
        .clk      (clk),
        .reset    (reset),
        .date     (date),
        .stime    (stime),
        .timer    (timer),
        .AD       (ad),
        .control  (control),
        .contador (contador),
        .cont     (cont),
        .counter  (counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: advance sequence position on each rising edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos <= -1;
        end else if (pos < 0) begin
            pos <= 0;
        end else if (pos < 144) begin
            pos <= pos + 1;
        end else if (date || stime || timer) begin
            pos <= 0;
        end else begin
            pos <= pos;
        end
    end

    function automatic void model_out(input int p, output logic [7:0] e_ad,
                                      output logic [3:0] e_ctl, output logic [7:0] e_idx,
                                      output logic [1:0] e_ph, output logic [5:0] e_cnt);
        int c;
        int k;
        logic csn;
        logic wrn;
        logic adn;
        if (p < 0) begin
            e_ad = 8'h00; e_ctl = 4'b1110; e_idx = 8'd0; e_ph = 2'd0; e_cnt = 6'd0;
        end else if (p >= 144) begin
            e_ad = 8'h00; e_ctl = 4'b1110; e_idx = 8'd6; e_ph = 2'd3; e_cnt = 6'd0;
        end else begin
            c     = p % 24;
            e_idx = 8'(p / 24);
            e_cnt = 6'(c);
            if (c < 10) begin
                e_ph = 2'd0; k = c; e_ad = taddr[p / 24]; adn = 1'b0;
            end else if (c < 20) begin
                e_ph = 2'd1; k = c - 10; e_ad = tdata[p / 24]; adn = 1'b1;
            end else begin
                e_ph = 2'd2; k = -1; e_ad = 8'h00; adn = 1'b0;
            end
            csn   = !(k >= 1 && k <= 8);
            wrn   = !(k >= 2 && k <= 7);
            e_ctl = {csn, 1'b1, wrn, adn};
        end
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Compare every output with the model on each falling edge.
    always @(negedge clk) begin
        logic [7:0] e_ad;
        logic [3:0] e_ctl;
        logic [7:0] e_idx;
        logic [1:0] e_ph;
        logic [5:0] e_cnt;
        if (run_en) begin
            model_out(pos, e_ad, e_ctl, e_idx, e_ph, e_cnt);
            cmp("model_AD", int'(ad), int'(e_ad));
            cmp("model_control", int'(control), int'(e_ctl));
            cmp("model_contador", int'(contador), int'(e_idx));
            cmp("model_cont", int'(cont), int'(e_ph));
            cmp("model_counter", int'(counter), int'(e_cnt));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; date = 1'b0; stime = 1'b0; timer = 1'b0;
        run_en = 1'b1;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;

        step(1);    // position 0
        cmp("first_AD", int'(ad), 'h02);
        cmp("first_control", int'(control), 'b1110);
        cmp("first_cont", int'(cont), 0);
        cmp("first_counter", int'(counter), 0);
        step(3);    // position 3: address write strobe
        cmp("addr_wr_control", int'(control), 'b0100);
        cmp("addr_wr_AD", int'(ad), 'h02);
        timer = 1'b1;   // ignored mid-write
        step(1);
        timer = 1'b0;
        step(9);    // position 13: data write strobe
        cmp("data_wr_control", int'(control), 'b0101);
        cmp("data_wr_AD", int'(ad), 'h10);
        cmp("data_cont", int'(cont), 1);
        step(7);    // position 20: recovery
        cmp("recov_control", int'(control), 'b1110);
        cmp("recov_AD", int'(ad), 'h00);
        cmp("recov_cont", int'(cont), 2);
        step(40);   // position 60: idx2 data
        cmp("idx2_AD", int'(ad), 'hD2);
        cmp("idx2_contador", int'(contador), 2);
        step(90);   // idle
        cmp("idle_contador", int'(contador), 6);
        cmp("idle_cont", int'(cont), 3);
        cmp("idle_control", int'(control), 'b1110);
        cmp("idle_AD", int'(ad), 'h00);
        cmp("idle_counter", int'(counter), 0);

        date = 1'b1;
        step(1);
        date = 1'b0;
        cmp("date_contador", int'(contador), 0);
        cmp("date_AD", int'(ad), 'h02);
        step(84);   // idx3, counter 12
        cmp("pre_rst_contador", int'(contador), 3);
        cmp("pre_rst_counter", int'(counter), 12);
        #2 reset = 1'b0;
        #1;
        cmp("async_rst_control", int'(control), 'b1110);
        cmp("async_rst_AD", int'(ad), 'h00);
        cmp("async_rst_counter", int'(counter), 0);
        cmp("async_rst_contador", int'(contador), 0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        step(1);
        cmp("rerun_AD", int'(ad), 'h02);
        cmp("rerun_contador", int'(contador), 0);

        step(150);
        date = 1'b1; stime = 1'b1; timer = 1'b1;
        step(1);
        date = 1'b0; stime = 1'b0; timer = 1'b0;
        cmp("multi_req_counter", int'(counter), 0);
        step(1);
        cmp("multi_req_single", int'(counter), 1);
        step(150);
        step(5);
        run_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
